// File: rtl/multiplier32bu_seq.sv
// Sequential unsigned radix-2 shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH bits in WIDTH cycles.
// Shares the start-edge / finish-level handshake of the sequential divider.
module multiplier32bu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   product,
    output logic                 finish,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 start_q;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 finish_q, finish_d;
    logic                 busy_q, busy_d;
    logic                 start_edge;
    logic [WIDTH:0]       sum;

    // Only a rising edge of start requests work; a held level never retriggers.
    assign start_edge = start & ~start_q;

    // Upper half plus multiplicand at WIDTH+1 bits keeps the carry for the shift.
    assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        finish_d  = finish_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    mcand_d  = a;
                    p_d      = {{WIDTH{1'b0}}, b};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    finish_d = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = p_d;
                    finish_d  = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            mcand_q   <= '0;
            p_q       <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            finish_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            finish_q  <= finish_d;
            busy_q    <= busy_d;
        end
    end

    assign product = product_q;
    assign finish  = finish_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_multiplier32bu_seq.sv
// Directed and random checks for multiplier32bu_seq: latency, handshake, hold, reset and exact products.
// Latency is counted in rising edges from the edge after which start is driven high.
module tb_multiplier32bu_seq;

    localparam int W = 32;

    logic             clk;
    logic             rst;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             start;
    logic [2*W-1:0]   product;
    logic             finish;
    logic             busy;

    int errors = 0;
    int checks = 0;

    multiplier32bu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .start   (start),
        .product (product),
        .finish  (finish),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for finish; reports edge count and observations.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int pulse_len,
                          output int edges, output int busy_cycles, output logic held_ok,
                          output logic fin_dropped);
        logic [2*W-1:0] old_p;
        old_p       = product;
        a           = ia;
        b           = ib;
        start       = 1'b1;
        edges       = 0;
        busy_cycles = 0;
        held_ok     = 1'b1;
        fin_dropped = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            edges++;
            if (edges == pulse_len) start = 1'b0;
            if (edges == 1 && finish === 1'b0) fin_dropped = 1'b1;
            if (busy === 1'b1) busy_cycles++;
            if (finish !== 1'b1 && product !== old_p) held_ok = 1'b0;
            if (finish === 1'b1) break;
        end
        start = 1'b0;
        if (finish !== 1'b1) edges = 999;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        checks++;
        if (product !== 64'h0) begin errors++; $display("FAIL reset_product got=%h exp=0", product); end
        checks++;
        if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", finish); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int e, bc;
        logic h, fd, hold_ok;
        run_op(32'd351, 32'd23, 1, e, bc, h, fd);
        checks++;
        if (e !== 33) begin errors++; $display("FAIL basic_latency got=%0d exp=33", e); end
        checks++;
        if (bc !== 32) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=32", bc); end
        checks++;
        if (product !== 64'h0000_0000_0000_1F89) begin
            errors++; $display("FAIL basic_product got=%h exp=%h", product, 64'h1F89);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (finish !== 1'b1 || product !== 64'h1F89 || busy !== 1'b0) hold_ok = 1'b0;
        end
        checks++;
        if (hold_ok !== 1'b1) begin
            errors++; $display("FAIL basic_hold got finish=%b product=%h exp finish=1 product=1f89", finish, product);
        end
    endtask

    task automatic test_restart();
        int e, bc;
        logic h, fd;
        run_op(32'd3, 32'd3, 2, e, bc, h, fd);
        checks++;
        if (e !== 33) begin errors++; $display("FAIL restart_latency got=%0d exp=33", e); end
        checks++;
        if (fd !== 1'b1) begin errors++; $display("FAIL restart_finish_drop got=%b exp=1", fd); end
        checks++;
        if (h !== 1'b1) begin errors++; $display("FAIL restart_product_held got=%b exp=1", h); end
        checks++;
        if (product !== 64'd9) begin errors++; $display("FAIL restart_product got=%h exp=9", product); end
        // A 2-cycle pulse must not have queued a second operation.
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || finish !== 1'b1) begin
            errors++; $display("FAIL restart_single_op got busy=%b finish=%b exp busy=0 finish=1", busy, finish);
        end
    endtask

    task automatic test_extremes();
        int e, bc;
        logic h, fd;
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, e, bc, h, fd);
        checks++;
        if (product !== 64'h3FFF_FFFF_0000_0001) begin
            errors++; $display("FAIL max_half_product got=%h exp=3fffffff00000001", product);
        end
        tick();
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, e, bc, h, fd);
        checks++;
        if (product !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL max_full_product got=%h exp=fffffffe00000001", product);
        end
        checks++;
        if (e !== 33) begin errors++; $display("FAIL max_full_latency got=%0d exp=33", e); end
    endtask

    task automatic test_ignore_run();
        int e, bc;
        logic h, fd;
        tick();
        a = 32'd351; b = 32'd23; start = 1'b1;
        e = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            e++;
            if (e == 1) start = 1'b0;
            if (e == 10) begin a = '0; b = '0; start = 1'b1; end
            if (e == 11) start = 1'b0;
            if (finish === 1'b1) break;
        end
        start = 1'b0;
        if (finish !== 1'b1) e = 999;
        checks++;
        if (e !== 33) begin errors++; $display("FAIL ignore_latency got=%0d exp=33", e); end
        checks++;
        if (product !== 64'h1F89) begin errors++; $display("FAIL ignore_product got=%h exp=1f89", product); end
        tick();
        run_op(32'h0, 32'hDEAD_BEEF, 1, e, bc, h, fd);
        checks++;
        if (e !== 33) begin errors++; $display("FAIL zero_latency got=%0d exp=33", e); end
        checks++;
        if (product !== 64'h0) begin errors++; $display("FAIL zero_product got=%h exp=0", product); end
    endtask

    task automatic test_reset_mid_run();
        int e;
        tick();
        a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || finish !== 1'b0 || product !== 64'h0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b finish=%b product=%h exp 0/0/0", busy, finish, product);
        end
        rst = 1'b0;
        e = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            e++;
            if (e == 1) start = 1'b0;
            if (finish === 1'b1) break;
        end
        start = 1'b0;
        if (finish !== 1'b1) e = 999;
        checks++;
        if (e !== 33) begin errors++; $display("FAIL post_reset_latency got=%0d exp=33", e); end
        checks++;
        if (product !== 64'h1_FFFF_FFFE) begin
            errors++; $display("FAIL post_reset_product got=%h exp=1fffffffe", product);
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        logic h, fd;
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] exp_p;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom_range(32'hFFFF_FFFF, 0));
            rb = W'($urandom_range(32'hFFFF_FFFF, 0));
            exp_p = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            run_op(ra, rb, 1, e, bc, h, fd);
            checks++;
            if (product !== exp_p || e !== 33) begin
                errors++;
                $display("FAIL rand_%0d a=%h b=%h got=%h exp=%h latency=%0d exp_latency=33",
                         n, ra, rb, product, exp_p, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_restart();
        test_extremes();
        test_ignore_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
